array_unpacked_dumper: RTL and testbench
========================================

// Module: array_unpacked_dumper
// PURPOSE
//  Hardware counterpart of the $writememb text format: reads words out of an external
//  WA x WB unpacked-array memory and streams them as ASCII bytes, one line per word.
//  Each line is WB chars '0'/'1', MSB first, terminated by '\n' (8'h0A); text reloads via $readmemb.
//  Sits between an on-chip RAM and a byte-stream sink (UART TX, trace FIFO, debug port).
// PARAMETERS
//  WA  8  memory depth in words (>=1)
//  WB  8  word width in bits (>=1)
//  AW  (WA>1)?$clog2(WA):1  address width (localparam, derived)
//  HD  (AW+3)/4  hex digits in address header (localparam, derived)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     1-cycle request to begin a dump; ignored while busy=1
//  base       in   AW    first word address, sampled with start; base>=WA treated as 0
//  cnt        in   AW+1  words to dump, sampled with start; cnt>WA clamped to WA
//  busy       out  1     high from cycle after accepted start until done
//  done       out  1     1-cycle pulse when last byte accepted (or empty dump finishes)
//  mem_rd     out  1     memory read strobe, 1 cycle per word
//  mem_addr   out  AW    memory read address, valid with mem_rd
//  mem_rdata  in   WB    read data, valid exactly 1 cycle after mem_rd
//  tx_data    out  8     ASCII byte
//  tx_valid   out  1     byte valid
//  tx_ready   in   1     sink accepts byte when tx_valid&&tx_ready
// BEHAVIOUR
//  Reset: busy=0 done=0 mem_rd=0 mem_addr=0 tx_valid=0 tx_data=8'h00; FSM->IDLE.
//  FSM: IDLE -> [HDR] -> RD -> WAIT -> BITS -> NL -> (RD | FIN) ; FIN -> IDLE.
//   IDLE: on start latch base/cnt (clamped); cnt==0 -> FIN (no bytes); else RD.
//   RD:   mem_rd=1, mem_addr=current address, 1 cycle.
//   WAIT: capture mem_rdata into shift reg, 1 cycle.
//   BITS: emit WB chars MSB first: bit 1 -> 8'h31, bit 0 -> 8'h30.
//   NL:   emit 8'h0A; word counter decrements; zero -> FIN, else address advances, -> RD.
//   FIN:  done=1 for 1 cycle, busy=0 in same cycle, -> IDLE.
//  Latency: start at edge k -> mem_rd in cycle k+1 -> first tx_valid in cycle k+3.
//  Stream: once tx_valid=1, tx_valid and tx_data held stable until accepted; never withdrawn.
//   Next byte presented the cycle after acceptance (1 byte/cycle max within a line).
//  Address: increments from base; WA-1 wraps to 0 (WA need not be a power of 2).
//   A dump of cnt=WA from base=B covers every word exactly once.
//  Per dump: exactly cnt*(WB+1) bytes (+ header, if enabled).
//  start while busy: ignored, no effect on latched base/cnt. start in FIN cycle: ignored.
//  Reset mid-operation: asynchronous, outputs to reset values immediately; partial line lost.
//  mem_rdata sampled only in WAIT; value on other cycles is don't-care.
// CONFIGURATION
//  ARRAY_DUMP_ADDR_EN defined: HDR state emits '@' (8'h40), HD lowercase hex digits of base
//   (MSB digit first, zero padded), then 8'h0A, before first RD; also emitted when cnt==0.
//   First tx_valid at cycle k+1; first mem_rd after header newline accepted.
//  Not defined: HDR state absent; stream contains only data lines, latency as above.
// TESTING
//  1 WA=8 WB=8, mem[i]=i, base=0 cnt=8, tx_ready=1 -> 72 bytes, line0 "00000000\n",
//    line7 "00000111\n", one done pulse, busy low after.
//  2 cnt=9 -> clamped: identical 72-byte stream as 1; cnt=7 -> 63 bytes, last "00000110\n".
//  3 base=6 cnt=4 -> mem_addr 6,7,0,1; lines "00000110","00000111","00000000","00000001".
//  4 scenario 1 with random tx_ready (~30% duty) -> same 72 bytes; tx_data stable while
//    tx_valid&&!tx_ready; start pulse mid-dump ignored.
//  5 cnt=0 -> no tx_valid, done 1 cycle later; rst_n low mid-line -> tx_valid=0 same cycle,
//    restart after reset yields full correct stream.
//  6 ARRAY_DUMP_ADDR_EN, WA=8 base=5 cnt=1 -> "@5\n" then "00000101\n" (mem[5]=5), 12 bytes.

Source files
------------

// File: rtl/array_unpacked_dumper_if.sv
// array_unpacked_dumper_if: control, memory-read and byte-stream signals of the dumper
// Parameters: WA memory depth, WB word width (AW derived as in the dumper)
// Signals: start/base/cnt request, busy/done status, mem_rd/mem_addr/mem_rdata read port,
//   tx_data/tx_valid/tx_ready byte stream
// Modports: slave = dumper side, master = requester / memory / sink side
interface array_unpacked_dumper_if #(
   parameter int WA = 8,
   parameter int WB = 8
);
   localparam int AW = (WA > 1) ? $clog2(WA) : 1;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   cnt;
   logic          busy;
   logic          done;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [WB-1:0] mem_rdata;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   modport slave (
      input  start, base, cnt, mem_rdata, tx_ready,
      output busy, done, mem_rd, mem_addr, tx_data, tx_valid
   );
   modport master (
      output start, base, cnt, mem_rdata, tx_ready,
      input  busy, done, mem_rd, mem_addr, tx_data, tx_valid
   );
endinterface

// File: rtl/array_unpacked_dumper.sv
// array_unpacked_dumper: streams WA x WB memory words as binary-text ASCII lines
// Optional '@<hex base>\n' header line enabled by defining ARRAY_DUMP_ADDR_EN.
// Ports: clk; rst_n asynchronous active-low reset;
//   bus (slave modport): start/base/cnt request, busy/done status,
//   mem_rd/mem_addr/mem_rdata memory read port (data one cycle after mem_rd),
//   tx_data/tx_valid/tx_ready byte stream (valid/data held until accepted)
module array_unpacked_dumper #(
   parameter int WA = 8,
   parameter int WB = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   array_unpacked_dumper_if.slave bus
);
   localparam int AW = (WA > 1) ? $clog2(WA) : 1;
   localparam int BW = (WB > 1) ? $clog2(WB) : 1;
   typedef enum logic [2:0] {
      S_IDLE,
`ifdef ARRAY_DUMP_ADDR_EN
      S_HDR,
`endif
      S_RD,
      S_WAIT,
      S_BITS,
      S_NL,
      S_FIN
   } state_t;
   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [WB-1:0] sh_q, sh_d;
   logic [BW-1:0] bi_q, bi_d;
   logic          acc;
   logic          in_hdr;
   logic [7:0]    hdr_byte;
`ifdef ARRAY_DUMP_ADDR_EN
   localparam int HD = (AW + 3) / 4;
   localparam int HW = $clog2(HD + 2);
   logic [HW-1:0]   hi_q, hi_d;
   logic [4*HD-1:0] hb;
   logic [3:0]      nib;
   // header byte index: 0 '@', 1..HD hex digits MSB first, HD+1 newline
   assign in_hdr   = state_q == S_HDR;
   assign hb       = (4*HD)'(addr_q);
   assign nib      = 4'(hb >> (4 * (HD - int'(hi_q))));
   assign hdr_byte = hi_q == '0 ? 8'h40 :
                     hi_q == HW'(HD + 1) ? 8'h0A :
                     nib < 4'd10 ? {4'h3, nib} : 8'h57 + {4'h0, nib};
`else
   assign in_hdr   = 1'b0;
   assign hdr_byte = 8'h00;
`endif
   assign acc          = bus.tx_valid && bus.tx_ready;
   assign bus.busy     = state_q != S_IDLE && state_q != S_FIN;
   assign bus.done     = state_q == S_FIN;
   assign bus.mem_rd   = state_q == S_RD;
   assign bus.mem_addr = addr_q;
   assign bus.tx_valid = state_q == S_BITS || state_q == S_NL || in_hdr;
   assign bus.tx_data  = state_q == S_BITS ? (sh_q[WB-1] ? 8'h31 : 8'h30) :
                         state_q == S_NL ? 8'h0A :
                         in_hdr ? hdr_byte : 8'h00;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bi_d    = bi_q;
`ifdef ARRAY_DUMP_ADDR_EN
      hi_d    = hi_q;
`endif
      case (state_q)
         S_IDLE: if (bus.start) begin
            // out-of-range base restarts at word 0; oversize count covers the array once
            addr_d  = int'(bus.base) >= WA ? '0 : bus.base;
            cnt_d   = int'(bus.cnt) > WA ? (AW+1)'(WA) : bus.cnt;
`ifdef ARRAY_DUMP_ADDR_EN
            hi_d    = '0;
            state_d = S_HDR;
`else
            state_d = cnt_d == '0 ? S_FIN : S_RD;
`endif
         end
`ifdef ARRAY_DUMP_ADDR_EN
         S_HDR: if (acc) begin
            hi_d = hi_q + 1'b1;
            if (hi_q == HW'(HD + 1)) state_d = cnt_q == '0 ? S_FIN : S_RD;
         end
`endif
         S_RD: state_d = S_WAIT;
         S_WAIT: begin
            sh_d    = bus.mem_rdata;
            bi_d    = BW'(WB - 1);
            state_d = S_BITS;
         end
         S_BITS: if (acc) begin
            sh_d = sh_q << 1;
            bi_d = bi_q - 1'b1;
            if (bi_q == '0) state_d = S_NL;
         end
         S_NL: if (acc) begin
            cnt_d   = cnt_q - 1'b1;
            // explicit wrap so non-power-of-two depths stay in range
            addr_d  = addr_q == AW'(WA - 1) ? '0 : addr_q + 1'b1;
            state_d = cnt_q == (AW+1)'(1) ? S_FIN : S_RD;
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         bi_q    <= '0;
`ifdef ARRAY_DUMP_ADDR_EN
         hi_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bi_q    <= bi_d;
`ifdef ARRAY_DUMP_ADDR_EN
         hi_q    <= hi_d;
`endif
      end
   end
endmodule

// File: tb/tb_array_unpacked_dumper.sv
// tb_array_unpacked_dumper: directed self-checking bench for array_unpacked_dumper
// Header expectations follow ARRAY_DUMP_ADDR_EN when it is defined for the build.
module tb_array_unpacked_dumper;
   localparam int WA = 8;
   localparam int WB = 8;
   localparam int AW = (WA > 1) ? $clog2(WA) : 1;
   localparam int HD = (AW + 3) / 4;
`ifdef ARRAY_DUMP_ADDR_EN
   localparam int HL = HD + 2;
`else
   localparam int HL = 0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            kk = 0;
   int            dones = 0;
   int            first_rd = -1;
   int            first_tv = -1;
   int            done_cyc = -1;
   logic          pend = 1'b0;
   logic [7:0]    pend_data = '0;
   logic [WB-1:0] mem [WA];
   logic [7:0]    got[$];
   logic [7:0]    exp_q[$];
   int            addrs[$];

   array_unpacked_dumper_if #(.WA(WA), .WB(WB)) bus ();
   array_unpacked_dumper #(.WA(WA), .WB(WB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cycle numbers recorded here count the cycle after edge n as n+1
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_rd) begin
            addrs.push_back(int'(bus.mem_addr));
            if (first_rd < 0) first_rd = cyc + 1;
         end
         if (bus.tx_valid && first_tv < 0) first_tv = cyc + 1;
         if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
         if (bus.done) begin
            dones++;
            done_cyc = cyc + 1;
            chk("busy_with_done", bus.busy, 1'b0);
         end
         if (pend) chk("hold_stable", {bus.tx_valid, bus.tx_data}, {1'b1, pend_data});
         pend = bus.tx_valid && !bus.tx_ready;
         pend_data = bus.tx_data;
      end else pend = 1'b0;
   end

   function automatic void build(input int b, input int c);
      exp_q.delete();
      if (b >= WA) b = 0;
      if (c > WA) c = WA;
`ifdef ARRAY_DUMP_ADDR_EN
      exp_q.push_back(8'h40);
      for (int d = HD - 1; d >= 0; d--) begin
         int n;
         n = (b >> (4 * d)) & 15;
         exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(87 + n));
      end
      exp_q.push_back(8'h0A);
`endif
      for (int i = 0; i < c; i++) begin
         logic [WB-1:0] w;
         w = mem[(b + i) % WA];
         for (int j = WB - 1; j >= 0; j--) exp_q.push_back(w[j] ? 8'h31 : 8'h30);
         exp_q.push_back(8'h0A);
      end
   endfunction

   function automatic int first_bad();
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= got.size() || got[i] !== exp_q[i]) return i;
      return got.size() == exp_q.size() ? -1 : exp_q.size();
   endfunction

   function automatic logic [8*(WB+1)-1:0] line_at(input int off);
      logic [8*(WB+1)-1:0] r;
      r = '0;
      for (int i = 0; i < WB + 1; i++)
         r = {r[8*WB-1:0], (off + i < got.size()) ? got[off + i] : 8'h00};
      return r;
   endfunction

   task automatic run_dump(input string tag, input int b, input int c, input int duty,
                           input bit inj, input int sl);
      build(b, c);
      got.delete();
      addrs.delete();
      dones = 0;
      first_rd = -1;
      first_tv = -1;
      done_cyc = -1;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.base = AW'(b);
      bus.cnt = (AW+1)'(c);
      kk = cyc + 1;
      repeat (sl) begin
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      for (int i = 0; i < 3000 && dones == 0; i++) begin
         bus.tx_ready = $urandom_range(99) < duty;
         bus.start = inj && i == 20;
         if (inj && i == 20) begin
            bus.base = AW'(3);
            bus.cnt = (AW+1)'(2);
         end
         @(posedge clk);
         #1;
      end
      bus.tx_ready = 1'b1;
      bus.start = 1'b0;
      chk({tag, "_done_seen"}, dones, 1);
      @(posedge clk);
      #1;
      chk({tag, "_busy_after"}, bus.busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_one_done"}, dones, 1);
      chk({tag, "_stream"}, first_bad(), -1);
   endtask

   initial begin
      for (int i = 0; i < WA; i++) mem[i] = WB'(i);
      bus.start = 1'b0;
      bus.base = '0;
      bus.cnt = '0;
      bus.tx_ready = 1'b1;
      #2;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_mem_rd", bus.mem_rd, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_dump("t1", 0, 8, 100, 1'b0, 1);
      chk("t1_len", got.size(), 72 + HL);
      chk("t1_line0", line_at(HL), "00000000\n");
      chk("t1_line7", line_at(HL + 63), "00000111\n");
      chk("t1_first_rd", first_rd, kk + 1 + HL);
      chk("t1_first_tv", first_tv, HL > 0 ? kk + 1 : kk + 3);
      chk("t1_reads", addrs.size(), 8);

      run_dump("t2a", 0, 9, 100, 1'b0, 1);
      chk("t2a_len", got.size(), 72 + HL);
      chk("t2a_line7", line_at(HL + 63), "00000111\n");
      run_dump("t2b", 0, 7, 100, 1'b0, 1);
      chk("t2b_len", got.size(), 63 + HL);
      chk("t2b_last", line_at(HL + 54), "00000110\n");

      run_dump("t3", 6, 4, 100, 1'b0, 1);
      chk("t3_nreads", addrs.size(), 4);
      chk("t3_addrs", {8'(addrs[0]), 8'(addrs[1]), 8'(addrs[2]), 8'(addrs[3])}, 32'h06070001);
      chk("t3_line0", line_at(HL), "00000110\n");
      chk("t3_line1", line_at(HL + 9), "00000111\n");
      chk("t3_line2", line_at(HL + 18), "00000000\n");
      chk("t3_line3", line_at(HL + 27), "00000001\n");

      run_dump("t4", 0, 8, 30, 1'b1, 1);
      chk("t4_len", got.size(), 72 + HL);
      chk("t4_line7", line_at(HL + 63), "00000111\n");

      // start held into the FIN cycle must not launch a second dump
      run_dump("t5a", 0, 0, 100, 1'b0, 2);
      chk("t5a_len", got.size(), HL);
      chk("t5a_done_cyc", done_cyc, kk + 1 + HL);
      chk("t5a_no_reads", addrs.size(), 0);

      got.delete();
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.base = '0;
      bus.cnt = (AW+1)'(8);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int i = 0; i < 200 && got.size() < HL + 4; i++) @(posedge clk);
      #3;
      chk("t5b_mid_line", bus.tx_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5b_rst_valid", bus.tx_valid, 1'b0);
      chk("t5b_rst_busy", bus.busy, 1'b0);
      chk("t5b_rst_data", bus.tx_data, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_dump("t5c", 0, 8, 100, 1'b0, 1);
      chk("t5c_len", got.size(), 72 + HL);

`ifdef ARRAY_DUMP_ADDR_EN
      run_dump("t6", 5, 1, 100, 1'b0, 1);
      chk("t6_len", got.size(), 12);
      chk("t6_hdr", {got[0], got[1], got[2]}, "@5\n");
      chk("t6_line", line_at(3), "00000101\n");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
